pwm_duty_ramp: RTL and testbench
================================

Name: pwm_duty_ramp

Overview:
- Upstream stage of the 8-bit PWM generator. Drives the PWM duty input.
- Accepts a target duty over a valid/ready handshake.
- Slews its duty output toward the target by a fixed step. Changes happen only at PWM period boundaries, so the PWM never sees a mid-period duty change.
- Keeps its own free-running 8-bit period counter. This counter stays in lockstep with the PWM's counter because both start at 0 out of reset.

Parameters:
- STEP, 16, duty increment/decrement per step event (1..255).
- PERIODS_PER_STEP, 1, number of full 256-clock PWM periods between step events (1..65535).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- tgt_din  input  8  requested target duty
- tgt_valid  input  1  tgt_din is valid
- tgt_ready  output  1  block can accept a target
- dout  output  8  current duty; connects to the PWM duty input
- period_start  output  1  one-cycle pulse on the cycle where period counter == 255 (the last cycle of the period)
- at_target  output  1  dout equals latched target; state is IDLE

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - period counter = 0, divider = 0, target = 0, dout = 0
  - state = IDLE, tgt_ready = 1, at_target = 1
  - period_start = 0 (it is combinational from the counter)
- Period counter:
  - 8-bit, increments every clk, wraps 255 -> 0.
  - Wrap edge = the rising edge at which the counter == 255.
- States: IDLE and RAMP.
  - tgt_ready = 1 in IDLE, 0 in RAMP (see Optional Feature for the exception).
- Handshake:
  - Transfer occurs on a rising edge where tgt_valid && tgt_ready.
  - target <= tgt_din.
  - If tgt_din == dout, stay in IDLE. Otherwise go to RAMP and clear the divider to 0.
  - tgt_din is ignored on cycles without a transfer.
- Step event: a wrap edge while in RAMP with divider == PERIODS_PER_STEP-1.
  - Divider: on other wrap edges in RAMP it increments; on a step event it clears to 0.
  - Up (dout < target): dout <= min(dout+STEP, target). Compute in 9 bits, so there is no 8-bit overflow.
  - Down (dout > target): dout <= max(dout-STEP, target). Compute as signed 9-bit, so there is no underflow.
  - If the new dout == target, go to IDLE on the same edge; tgt_ready = 1 on the next cycle.
- Timing: dout changes only on wrap edges, so each new value is valid from counter == 0 (first cycle of the next PWM period).
- Latency: an accepted target produces its first dout change at the step event reached after PERIODS_PER_STEP wrap edges.
- Divider width: 16 bits.
- Reset mid-ramp: abort immediately to reset values; the in-flight target is discarded.

Optional Feature:
- Macro: PWM_DUTY_RAMP_RETARGET_EN.
- Defined:
  - tgt_ready = 1 in both states; a new target may be accepted during RAMP.
  - Divider is NOT cleared on retarget.
  - If a transfer coincides with a step event, the step is computed toward the newly accepted target on that same edge.
  - If the new target equals the current dout (or the post-step dout), go to IDLE.
- Undefined: tgt_ready = 0 throughout RAMP; tgt_valid during RAMP is ignored and the held value is taken when the block returns to IDLE.

Test Plan:
- Reset, then hold idle for 300 cycles:
  - dout = 0, tgt_ready = 1, at_target = 1.
  - period_start pulses at cycles 255 and 511 after reset release.
- STEP=16, PERIODS_PER_STEP=1, target 64 accepted from 0:
  - dout = 16, 32, 48, 64, appearing at counter == 0 of successive periods.
  - at_target rises with the 64.
  - tgt_ready is 0 between acceptance and that point.
- Saturation, from dout=64:
  - Target 70 gives dout = 70 in one step (not 80).
  - Then target 0 gives 54, 38, 22, 6, 0 (clamped, no wrap to 246).
- PERIODS_PER_STEP=3, target 32 from 0:
  - dout changes only on every third wrap edge, to 16 then 32.
  - dout is constant across the intermediate periods.
- Assert rst mid-ramp (dout=32, target=128), asynchronously mid-cycle:
  - dout = 0, tgt_ready = 1, at_target = 1 before the next clk edge.
  - The period counter restarts at 0.
- Retarget during RAMP (from 0, target 128):
  - Without RETARGET_EN: a tgt_valid pulse with 10 during RAMP is ignored and the ramp completes to 128.
  - With RETARGET_EN: 10 is accepted after dout=32, and dout ramps down to 16 then 10.

Source files
------------

// File: rtl/pwm_duty_ramp.sv
// Duty-cycle slew stage ahead of the 8-bit PWM: accepts a target duty and steps dout toward it at PWM period boundaries.
// Optional: define PWM_DUTY_RAMP_RETARGET_EN to accept new targets while ramping.
module pwm_duty_ramp #(
    parameter int unsigned STEP             = 16,
    parameter int unsigned PERIODS_PER_STEP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tgt_din,
    input  logic       tgt_valid,
    output logic       tgt_ready,
    output logic [7:0] dout,
    output logic       period_start,
    output logic       at_target
);

    localparam int unsigned DW       = 8;
    localparam int unsigned DIVW     = 16;
    localparam logic [DW-1:0]   STEP_W   = DW'(STEP);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(PERIODS_PER_STEP - 1);

    typedef enum logic {IDLE, RAMP} state_t;

    state_t          r_state, w_state_nx;
    logic [DW-1:0]   r_cnt;
    logic [DIVW-1:0] r_div, w_div_nx;
    logic [DW-1:0]   r_target, w_target_nx;
    logic [DW-1:0]   r_dout, w_dout_nx;

    logic            w_wrap, w_xfer, w_step;
    logic [DW-1:0]   w_goal, w_up_val, w_dn_val, w_step_val;
    logic [DW:0]     w_up_sum;
    logic signed [DW:0] w_dn_diff;

    assign w_wrap = (r_cnt == 8'hFF);
    assign w_xfer = tgt_valid && tgt_ready;
    assign w_step = w_wrap && (r_state == RAMP) && (r_div == DIV_LAST);
    // A target accepted on a step edge steers that same step.
    assign w_goal = w_xfer ? tgt_din : r_target;

    // Saturating step toward w_goal; widened by one bit so it cannot wrap.
    assign w_up_sum   = {1'b0, r_dout} + {1'b0, STEP_W};
    assign w_dn_diff  = $signed({1'b0, r_dout}) - $signed({1'b0, STEP_W});
    assign w_up_val   = (w_up_sum >= {1'b0, w_goal}) ? w_goal : w_up_sum[DW-1:0];
    assign w_dn_val   = (w_dn_diff <= $signed({1'b0, w_goal})) ? w_goal : w_dn_diff[DW-1:0];
    assign w_step_val = (r_dout < w_goal) ? w_up_val :
                        (r_dout > w_goal) ? w_dn_val : r_dout;

`ifdef PWM_DUTY_RAMP_RETARGET_EN
    assign tgt_ready = 1'b1;
`else
    assign tgt_ready = (r_state == IDLE);
`endif

    assign dout         = r_dout;
    assign period_start = w_wrap;
    assign at_target    = (r_state == IDLE) && (r_dout == r_target);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_div    <= '0;
            r_target <= '0;
            r_dout   <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= DW'(r_cnt + 8'd1);
            r_div    <= w_div_nx;
            r_target <= w_target_nx;
            r_dout   <= w_dout_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_div_nx    = r_div;
        w_target_nx = r_target;
        w_dout_nx   = r_dout;

        if (w_xfer) w_target_nx = tgt_din;

        case (r_state)
            IDLE: begin
                if (w_xfer && (tgt_din != r_dout)) begin
                    w_state_nx = RAMP;
                    w_div_nx   = '0;
                end
            end
            RAMP: begin
                if (w_wrap) w_div_nx = w_step ? '0 : DIVW'(r_div + 16'd1);
                if (w_step) w_dout_nx = w_step_val;
                // Finish when the step lands on the goal, or a retarget already matches dout.
                if (w_step ? (w_step_val == w_goal) : (w_goal == r_dout))
                    w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp: one instance with STEP=16/PERIODS_PER_STEP=1, one with PERIODS_PER_STEP=3.
module tb_pwm_duty_ramp;

`ifdef PWM_DUTY_RAMP_RETARGET_EN
    localparam bit RT = 1'b1;
`else
    localparam bit RT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din_a = '0, din_b = '0;
    logic       val_a = 1'b0, val_b = 1'b0;
    logic       rdy_a, rdy_b, ps_a, ps_b, at_a, at_b;
    logic [7:0] dout_a, dout_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pwm_duty_ramp #(.STEP(16), .PERIODS_PER_STEP(1)) u_dut_a (
        .clk(clk), .rst(rst), .tgt_din(din_a), .tgt_valid(val_a), .tgt_ready(rdy_a),
        .dout(dout_a), .period_start(ps_a), .at_target(at_a)
    );

    pwm_duty_ramp #(.STEP(16), .PERIODS_PER_STEP(3)) u_dut_b (
        .clk(clk), .rst(rst), .tgt_din(din_b), .tgt_valid(val_b), .tgt_ready(rdy_b),
        .dout(dout_b), .period_start(ps_b), .at_target(at_b)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One-cycle valid pulse; ends on the negedge after the sampling edge.
    task automatic send(input int sel, input logic [7:0] v);
        @(negedge clk);
        if (sel == 0) begin din_a = v; val_a = 1'b1; end
        else          begin din_b = v; val_b = 1'b1; end
        @(negedge clk);
        val_a = 1'b0;
        val_b = 1'b0;
    endtask

    // Advance to the negedge where the counter is 0 (just after the next wrap edge).
    task automatic wait_wrap();
        int k = 0;
        while (!ps_a && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) chk("wrap_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic step_chk(input int sel, input int exp, input bit last, input string tag);
        wait_wrap();
        chk({tag, "_dout"}, (sel == 0) ? int'(dout_a) : int'(dout_b), exp);
        chk({tag, "_at"},   (sel == 0) ? int'(at_a)   : int'(at_b),   int'(last));
        chk({tag, "_rdy"},  (sel == 0) ? int'(rdy_a)  : int'(rdy_b),  int'(RT | last));
    endtask

    initial begin
        int p0 = -1, p1 = -1, np = 0;
        int seq_b[6] = '{0, 0, 16, 16, 16, 32};

        // Reset state and idle period_start cadence.
        #1;
        repeat (2) @(negedge clk);
        chk("rst_dout", int'(dout_a), 0);
        chk("rst_rdy", int'(rdy_a), 1);
        chk("rst_at", int'(at_a), 1);
        chk("rst_ps", int'(ps_a), 0);
        rst = 1'b0;
        for (int n = 0; n < 520; n++) begin
            if (ps_a) begin
                np++;
                if (p0 < 0) p0 = n; else if (p1 < 0) p1 = n;
            end
            @(negedge clk);
        end
        chk("ps_first", p0, 255);
        chk("ps_second", p1, 511);
        chk("ps_count", np, 2);
        chk("idle_dout", int'(dout_a), 0);
        chk("idle_rdy", int'(rdy_a), 1);
        chk("idle_at", int'(at_a), 1);

        // Ramp 0 -> 64.
        send(0, 8'd64);
        chk("acc_rdy", int'(rdy_a), int'(RT));
        chk("acc_dout", int'(dout_a), 0);
        step_chk(0, 16, 1'b0, "up16");
        step_chk(0, 32, 1'b0, "up32");
        step_chk(0, 48, 1'b0, "up48");
        step_chk(0, 64, 1'b1, "up64");

        // Saturation both directions.
        send(0, 8'd70);
        step_chk(0, 70, 1'b1, "sat70");
        send(0, 8'd0);
        step_chk(0, 54, 1'b0, "dn54");
        step_chk(0, 38, 1'b0, "dn38");
        step_chk(0, 22, 1'b0, "dn22");
        step_chk(0, 6,  1'b0, "dn6");
        step_chk(0, 0,  1'b1, "dn0");

        // PERIODS_PER_STEP=3: only every third wrap edge steps.
        send(1, 8'd32);
        for (int i = 0; i < 6; i++)
            step_chk(1, seq_b[i], (i == 5), $sformatf("pps3_w%0d", i));

        // Asynchronous reset mid-ramp at dout=32, target=128.
        send(0, 8'd128);
        step_chk(0, 16, 1'b0, "pre16");
        step_chk(0, 32, 1'b0, "pre32");
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_dout", int'(dout_a), 0);
        chk("mid_rst_rdy", int'(rdy_a), 1);
        chk("mid_rst_at", int'(at_a), 1);
        chk("mid_rst_ps", int'(ps_a), 0);
        #1 rst = 1'b0;
        for (int n = 1; n <= 255; n++) begin
            @(negedge clk);
            if (n == 254) chk("rerun_ps254", int'(ps_a), 0);
            if (n == 255) chk("rerun_ps255", int'(ps_a), 1);
        end
        chk("rerun_dout", int'(dout_a), 0);

        // Retarget to 10 while ramping toward 128.
        send(0, 8'd128);
        step_chk(0, 16, 1'b0, "rt16");
        step_chk(0, 32, 1'b0, "rt32");
        send(0, 8'd10);
        chk("rt_hold", int'(dout_a), 32);
`ifdef PWM_DUTY_RAMP_RETARGET_EN
        step_chk(0, 16, 1'b0, "rtd16");
        step_chk(0, 10, 1'b1, "rtd10");
`else
        step_chk(0, 48,  1'b0, "ign48");
        step_chk(0, 64,  1'b0, "ign64");
        step_chk(0, 80,  1'b0, "ign80");
        step_chk(0, 96,  1'b0, "ign96");
        step_chk(0, 112, 1'b0, "ign112");
        step_chk(0, 128, 1'b1, "ign128");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
